mul_issue_stage: RTL and testbench

Two-stage valid/ready pipeline wrapper around the `multiplier_signed` carry-save array. It accepts RISC-V M-extension multiply operations (MUL, MULH, MULHSU, MULHU) from the execute stage. It registers the operands and decodes the op into the array's `sign`/`mix` controls, then captures the 2·SIZE product and returns the selected SIZE-bit half with its tag to writeback.

---
 rtl/mul_pkg.sv | 33 +++
 rtl/multiplier_signed.sv | 65 ++++++
 rtl/mul_issue_stage.sv | 103 ++++++++++
 tb/tb_mul_issue_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiply issue stage: RISC-V M-extension multiply
// opcodes and their decode into multiplier array controls.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  // sign: both operands signed; mix: a signed, b unsigned; hi: return upper half.
  typedef struct packed {
    logic sign;
    logic mix;
    logic hi;
  } mul_ctrl_t;

  function automatic mul_ctrl_t mul_decode(input mul_op_t op);
    mul_ctrl_t c;
    c.sign = 1'b0;
    c.mix  = 1'b0;
    c.hi   = 1'b1;
    case (op)
      MUL:     c.hi   = 1'b0;
      MULH:    c.sign = 1'b1;
      MULHSU:  c.mix  = 1'b1;
      default: c.hi   = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multiplier_signed.sv
// Carry-save array multiplier with signed/mixed/unsigned operand modes and a
// Sklansky prefix adder resolving the final sum/carry pair.
module multiplier_signed #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0]   i_a,
  input  logic [SIZE-1:0]   i_b,
  input  logic              i_sign,
  input  logic              i_mix,
  output logic [2*SIZE-1:0] o_y
);

  localparam int W    = 2 * SIZE;
  localparam int LVLS = $clog2(W);

  logic [W-1:0] w_a_ext;
  logic         w_b_neg;
  logic [W-1:0] w_sum;
  logic [W-1:0] w_carry;

  assign w_a_ext = {{SIZE{(i_sign | i_mix) & i_a[SIZE-1]}}, i_a};
  // A signed b contributes -b[MSB]*2^SIZE: that row is added as ~(a<<SIZE) + 1.
  assign w_b_neg = i_sign & i_b[SIZE-1];

  always_comb begin
    logic [W-1:0] pp;
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic [W-1:0] ns;
    pp = '0;
    ns = '0;
    s  = i_b[0] ? w_a_ext : '0;
    c  = {{(W-1){1'b0}}, w_b_neg};
    for (int i = 1; i <= SIZE; i++) begin
      if (i < SIZE) pp = i_b[i] ? (w_a_ext << i) : '0;
      else          pp = w_b_neg ? ~(w_a_ext << SIZE) : '0;
      ns = s ^ c ^ pp;
      c  = ((s & c) | (s & pp) | (c & pp)) << 1;
      s  = ns;
    end
    w_sum   = s;
    w_carry = c;
  end

  always_comb begin
    logic [W-1:0] g;
    logic [W-1:0] p;
    int           j;
    j = 0;
    g = w_sum & w_carry;
    p = w_sum ^ w_carry;
    // Nodes with bit l set combine with the last node of the lower block.
    for (int l = 0; l < LVLS; l++) begin
      for (int i = 0; i < W; i++) begin
        if (((i >> l) & 1) == 1) begin
          j    = ((i >> l) << l) - 1;
          g[i] = g[i] | (p[i] & g[j]);
          p[i] = p[i] & p[j];
        end
      end
    end
    o_y = (w_sum ^ w_carry) ^ {g[W-2:0], 1'b0};
  end

endmodule

// File: rtl/mul_issue_stage.sv
// Two-stage valid/ready wrapper around multiplier_signed: S1 holds operands and
// feeds the array, S2 captures the selected product half for writeback.
module mul_issue_stage
  import mul_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [SIZE-1:0]  in_a,
  input  logic [SIZE-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      op_count
);

  // Handshake: a transfer happens on any edge where valid && ready; S2 is free
  // when empty or retiring, and S1 accepts when empty or able to advance.
  logic             r_s1_valid;
  logic [SIZE-1:0]  r_s1_a;
  logic [SIZE-1:0]  r_s1_b;
  logic [1:0]       r_s1_op;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid;
  logic [SIZE-1:0]  r_s2_result;
  logic [TAG_W-1:0] r_s2_tag;
  logic [31:0]      r_op_count;

  logic              w_s2_free;
  logic              w_advance;
  logic              w_load;
  logic              w_retire;
  mul_ctrl_t         w_ctrl;
  logic [2*SIZE-1:0] w_y;

  assign w_s2_free = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign w_load    = in_valid && in_ready && !flush;
  assign w_advance = r_s1_valid && w_s2_free;
  assign w_retire  = r_s2_valid && out_ready;
  assign w_ctrl    = mul_decode(mul_op_t'(r_s1_op));

  multiplier_signed #(.SIZE(SIZE)) u_mul (
    .i_a    (r_s1_a),
    .i_b    (r_s1_b),
    .i_sign (w_ctrl.sign),
    .i_mix  (w_ctrl.mix),
    .o_y    (w_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
      r_s1_tag   <= '0;
    end else begin
      if (flush)          r_s1_valid <= 1'b0;
      else if (w_load)    r_s1_valid <= 1'b1;
      else if (w_advance) r_s1_valid <= 1'b0;
      if (w_load) begin
        r_s1_a   <= in_a;
        r_s1_b   <= in_b;
        r_s1_op  <= in_op;
        r_s1_tag <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_tag    <= '0;
      r_op_count  <= '0;
    end else begin
      if (flush)          r_s2_valid <= 1'b0;
      else if (w_advance) r_s2_valid <= 1'b1;
      else if (w_retire)  r_s2_valid <= 1'b0;
      if (w_advance && !flush) begin
        r_s2_result <= w_ctrl.hi ? w_y[2*SIZE-1:SIZE] : w_y[SIZE-1:0];
        r_s2_tag    <= r_s1_tag;
      end
      if (w_retire) r_op_count <= r_op_count + 32'd1;
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_tag    = r_s2_tag;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_mul_issue_stage.sv
// Bench for mul_issue_stage: directed corner products, backpressure, flush,
// reset and counter wrap, plus random traffic against an ordered result model.
module tb_mul_issue_stage;

  localparam int SIZE  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [SIZE-1:0]  in_a;
  logic [SIZE-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic [31:0]      op_count;

  always #5 clk = ~clk;

  mul_issue_stage #(.SIZE(SIZE), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .op_count   (op_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [TAG_W+SIZE-1:0] exp_q[$];
  logic [31:0] exp_count;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: full 64-bit product of the extended operands, then pick a half.
  function automatic logic [SIZE-1:0] ref_mul(input logic [1:0] op, input logic [SIZE-1:0] a,
                                              input logic [SIZE-1:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd1:    p = sa * sb;
      2'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [SIZE-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock: drive at the falling edge, evaluate handshakes, advance to next falling edge.
  task automatic step_cycle(input logic v, input logic [1:0] op, input logic [SIZE-1:0] a,
                            input logic [SIZE-1:0] b, input logic [TAG_W-1:0] tg,
                            input logic ordy, input logic fl, input logic has_exp,
                            input logic [SIZE-1:0] xv, output logic acc);
    logic [TAG_W+SIZE-1:0] e;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    #1;
    acc = v && in_ready && !fl;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", {63'd0, out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_result", {32'd0, out_result}, {32'd0, e[SIZE-1:0]});
        check_eq("out_tag", {59'd0, out_tag}, {59'd0, e[TAG_W+SIZE-1:SIZE]});
      end
      exp_count = exp_count + 32'd1;
    end
    if (fl) exp_q.delete();
    if (acc) exp_q.push_back({tg, has_exp ? xv : ref_mul(op, a, b)});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step_cycle(1'b0, 2'd0, '0, '0, '0, ordy, 1'b0, 1'b0, '0, acc);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1'b1);
    idle(1'b1);
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    check_eq("op_count", {32'd0, op_count}, {32'd0, exp_count});
  endtask

  logic [1:0]       d_op [6] = '{2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
  logic [SIZE-1:0]  d_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000,
                                 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0007};
  logic [SIZE-1:0]  d_b  [6] = '{32'hFFFF_FFFF, 32'h0000_0003, 32'h8000_0000,
                                 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0006};
  logic [SIZE-1:0]  d_y  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000,
                                 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_002A};

  initial begin
    logic acc;
    logic saw_stall;
    int   cyc;
    int   k;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_tag = '0; out_ready = 1'b0; exp_count = '0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_out_result", {32'd0, out_result}, 64'd0);
    check_eq("rst_out_tag", {59'd0, out_tag}, 64'd0);
    check_eq("rst_op_count", {32'd0, op_count}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Latency: accepted at edge N, visible after edge N+1.
    step_cycle(1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b0, 1'b1, 32'h1, acc);
    check_eq("lat_accept", {63'd0, acc}, 64'd1);
    check_eq("lat_not_yet", {63'd0, out_valid}, 64'd0);
    idle(1'b0);
    check_eq("lat_two_cycles", {63'd0, out_valid}, 64'd1);
    check_eq("lat_result", {32'd0, out_result}, 64'd1);
    idle(1'b1);

    for (int i = 0; i < 6; i++)
      step_cycle(1'b1, d_op[i], d_a[i], d_b[i], 5'(i + 1), 1'b1, 1'b0, 1'b1, d_y[i], acc);
    drain();

    // Back-to-back four ops with a 3-cycle output stall after the first result.
    saw_stall = 1'b0;
    cyc = 0;
    k = 1;
    while (k <= 4 && cyc < 30) begin
      step_cycle(1'b1, 2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 5'(k),
                 !(cyc >= 2 && cyc < 5), 1'b0, 1'b0, '0, acc);
      if (acc) k++;
      else saw_stall = 1'b1;
      cyc++;
    end
    check_eq("bp_all_accepted", 64'(k), 64'd5);
    check_eq("bp_in_ready_dropped", {63'd0, saw_stall}, 64'd1);
    drain();

    for (int n = 0; n < 400; n++)
      step_cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), pick_operand(),
                 pick_operand(), 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                 1'b0, 1'b0, '0, acc);
    drain();

    // Flush with both stages full and input offered.
    step_cycle(1'b1, 2'd0, 32'd3, 32'd5, 5'd9, 1'b0, 1'b0, 1'b0, '0, acc);
    step_cycle(1'b1, 2'd3, 32'd11, 32'd13, 5'd10, 1'b0, 1'b0, 1'b0, '0, acc);
    check_eq("flush_pre_full", {62'd0, out_valid, in_ready}, 64'd2);
    step_cycle(1'b1, 2'd1, 32'd17, 32'd19, 5'd11, 1'b0, 1'b1, 1'b0, '0, acc);
    check_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("flush_in_ready", {63'd0, in_ready}, 64'd1);
    step_cycle(1'b1, 2'd0, 32'd23, 32'd29, 5'd12, 1'b1, 1'b1, 1'b0, '0, acc);
    repeat (3) idle(1'b1);
    check_eq("flush_op_count", {32'd0, op_count}, {32'd0, exp_count});

    // Counter wrap.
    force dut.r_op_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_op_count;
    exp_count = 32'hFFFF_FFFF;
    step_cycle(1'b1, 2'd0, 32'd2, 32'd3, 5'd13, 1'b1, 1'b0, 1'b0, '0, acc);
    drain();
    check_eq("wrap_zero", {32'd0, op_count}, 64'd0);

    // Asynchronous reset with a stalled result in S2.
    step_cycle(1'b1, 2'd0, 32'd5, 32'd7, 5'd21, 1'b0, 1'b0, 1'b0, '0, acc);
    idle(1'b0);
    idle(1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("arst_out_result", {32'd0, out_result}, 64'd0);
    check_eq("arst_out_tag", {59'd0, out_tag}, 64'd0);
    check_eq("arst_op_count", {32'd0, op_count}, 64'd0);
    exp_q.delete();
    exp_count = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) idle(1'b1);
    check_eq("post_rst_op_count", {32'd0, op_count}, {32'd0, exp_count});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
